// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush control slice.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_WAIT = 2'd1,
    MEM_WAIT = 2'd2
  } stall_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // True when a producer register is nonzero and feeds either ID source.
  function automatic logic reg_match(input logic [4:0] rd,
                                     input logic [4:0] rs1,
                                     input logic [4:0] rs2);
    return (rd != REG_ZERO) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/stall_cycle_counter.sv
// Saturating counter of cycles in which the front end (PC) was held.
module stall_cycle_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  // Count up on each held cycle, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the five-stage pipeline: combines ID hazards,
// MUL/DIV occupancy and data-memory wait states into stage enables/flushes.
module pipeline_stall_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           rs1_address_id_i,
  input  logic [4:0]           rs2_address_id_i,
  input  logic                 branch_id_i,
  input  logic [4:0]           rd_address_ex_i,
  input  logic                 reg_write_ex_i,
  input  logic                 mem_to_reg_ex_i,
  input  logic                 mdu_op_ex_i,
  input  logic [4:0]           rd_address_mem_i,
  input  logic                 mem_to_reg_mem_i,
  input  logic                 dmem_req_mem_i,
  input  logic                 dmem_ack_i,
  input  logic                 mdu_done_i,
  output logic                 mdu_start_o,
  output logic                 pc_en_o,
  output logic                 if_id_en_o,
  output logic                 id_ex_en_o,
  output logic                 ex_mem_en_o,
  output logic                 mem_wb_en_o,
  output logic                 id_ex_flush_o,
  output logic                 ex_mem_flush_o,
  output logic                 mem_wb_flush_o,
  output logic [CNT_WIDTH-1:0] stall_cycles_o
);

  stall_state_e state;
  stall_state_e state_next;

  logic mem_stall;
  logic ex_match;
  logic mem_match;
  logic load_use_hazard;
  logic branch_hazard;
  logic id_hazard;

  assign mem_stall       = dmem_req_mem_i & ~dmem_ack_i;
  assign ex_match        = reg_match(rd_address_ex_i, rs1_address_id_i, rs2_address_id_i);
  assign mem_match       = reg_match(rd_address_mem_i, rs1_address_id_i, rs2_address_id_i);
  assign load_use_hazard = mem_to_reg_ex_i & ex_match;
  assign branch_hazard   = branch_id_i & ((reg_write_ex_i & ex_match) |
                                          (mem_to_reg_mem_i & mem_match));
  assign id_hazard       = load_use_hazard | branch_hazard;

  // Decode stage controls and next state from priority: memory wait, then MDU, then ID hazards.
  always_comb begin
    state_next     = state;
    mdu_start_o    = 1'b0;
    pc_en_o        = 1'b1;
    if_id_en_o     = 1'b1;
    id_ex_en_o     = 1'b1;
    ex_mem_en_o    = 1'b1;
    mem_wb_en_o    = 1'b1;
    id_ex_flush_o  = 1'b0;
    ex_mem_flush_o = 1'b0;
    mem_wb_flush_o = 1'b0;
    if (reset) begin
      id_ex_flush_o  = 1'b1;
      ex_mem_flush_o = 1'b1;
      mem_wb_flush_o = 1'b1;
      state_next     = RUN;
    end else if (mem_stall) begin
      pc_en_o        = 1'b0;
      if_id_en_o     = 1'b0;
      id_ex_en_o     = 1'b0;
      ex_mem_en_o    = 1'b0;
      mem_wb_flush_o = 1'b1;
      state_next     = (state == MDU_WAIT) ? MDU_WAIT : MEM_WAIT;
    end else begin
      case (state)
        MEM_WAIT: begin
          state_next = RUN;
        end
        MDU_WAIT: begin
          if (mdu_done_i) begin
            state_next = RUN;
          end else begin
            pc_en_o        = 1'b0;
            if_id_en_o     = 1'b0;
            id_ex_en_o     = 1'b0;
            ex_mem_flush_o = 1'b1;
          end
        end
        RUN: begin
          if (mdu_op_ex_i) begin
            mdu_start_o    = 1'b1;
            pc_en_o        = 1'b0;
            if_id_en_o     = 1'b0;
            id_ex_en_o     = 1'b0;
            ex_mem_flush_o = 1'b1;
            state_next     = MDU_WAIT;
          end else if (id_hazard) begin
            pc_en_o       = 1'b0;
            if_id_en_o    = 1'b0;
            id_ex_flush_o = 1'b1;
          end
        end
        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

  // Sequencer state register; reset always returns to RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  stall_cycle_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_stall_cycle_counter (
    .clk  (clk),
    .reset(reset),
    .inc  (~pc_en_o),
    .count(stall_cycles_o)
  );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench for pipeline_stall_controller: directed scenarios followed
// by randomized traffic, all compared against a behavioural pipeline model.
module tb_pipeline_stall_controller;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic [4:0]       rs1_id;
  logic [4:0]       rs2_id;
  logic             branch_id;
  logic [4:0]       rd_ex;
  logic             reg_write_ex;
  logic             load_ex;
  logic             mdu_op_ex;
  logic [4:0]       rd_mem;
  logic             load_mem;
  logic             dmem_req;
  logic             dmem_ack;
  logic             mdu_done;
  logic             mdu_start;
  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic             mem_wb_flush;
  logic [CNT_W-1:0] stall_cycles;

  int vectors    = 0;
  int miscompares = 0;
  string phase = "init";

  // Model state: an MDU op has been launched and not yet accepted, and a
  // memory wait that began outside an MDU op is waiting for its release cycle.
  bit m_mdu_busy    = 1'b0;
  bit m_mem_waiting = 1'b0;
  int m_cnt         = 0;

  bit e_start, e_pc, e_ifid, e_idex, e_exmem, e_memwb, e_fidex, e_fexmem, e_fmemwb;

  pipeline_stall_controller #(
    .CNT_WIDTH(CNT_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .rs1_address_id_i(rs1_id),
    .rs2_address_id_i(rs2_id),
    .branch_id_i     (branch_id),
    .rd_address_ex_i (rd_ex),
    .reg_write_ex_i  (reg_write_ex),
    .mem_to_reg_ex_i (load_ex),
    .mdu_op_ex_i     (mdu_op_ex),
    .rd_address_mem_i(rd_mem),
    .mem_to_reg_mem_i(load_mem),
    .dmem_req_mem_i  (dmem_req),
    .dmem_ack_i      (dmem_ack),
    .mdu_done_i      (mdu_done),
    .mdu_start_o     (mdu_start),
    .pc_en_o         (pc_en),
    .if_id_en_o      (if_id_en),
    .id_ex_en_o      (id_ex_en),
    .ex_mem_en_o     (ex_mem_en),
    .mem_wb_en_o     (mem_wb_en),
    .id_ex_flush_o   (id_ex_flush),
    .ex_mem_flush_o  (ex_mem_flush),
    .mem_wb_flush_o  (mem_wb_flush),
    .stall_cycles_o  (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A value ID needs is not yet obtainable by forwarding if it is still being
  // loaded in EX, or (for an ID-stage compare) still computed in EX or loaded in MEM.
  function automatic bit id_needs_stall();
    logic [4:0] pending[$];
    if (load_ex) pending.push_back(rd_ex);
    if (branch_id && reg_write_ex) pending.push_back(rd_ex);
    if (branch_id && load_mem) pending.push_back(rd_mem);
    foreach (pending[i]) begin
      if (pending[i] != 5'd0 && (pending[i] == rs1_id || pending[i] == rs2_id)) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Expected controls for the current inputs and model state.
  task automatic model_outputs();
    e_start = 0; e_pc = 1; e_ifid = 1; e_idex = 1; e_exmem = 1; e_memwb = 1;
    e_fidex = 0; e_fexmem = 0; e_fmemwb = 0;
    if (reset) begin
      e_fidex = 1; e_fexmem = 1; e_fmemwb = 1;
    end else if (dmem_req && !dmem_ack) begin
      e_pc = 0; e_ifid = 0; e_idex = 0; e_exmem = 0; e_fmemwb = 1;
    end else if (m_mem_waiting) begin
      e_pc = 1;
    end else if (m_mdu_busy) begin
      if (!mdu_done) begin
        e_pc = 0; e_ifid = 0; e_idex = 0; e_fexmem = 1;
      end
    end else if (mdu_op_ex) begin
      e_start = 1; e_pc = 0; e_ifid = 0; e_idex = 0; e_fexmem = 1;
    end else if (id_needs_stall()) begin
      e_pc = 0; e_ifid = 0; e_fidex = 1;
    end
  endtask

  // Advance the model across one clock edge.
  task automatic model_advance();
    if (reset) begin
      m_mdu_busy = 0; m_mem_waiting = 0; m_cnt = 0;
    end else begin
      if (!e_pc && m_cnt < CNT_MAX) m_cnt++;
      if (dmem_req && !dmem_ack) begin
        if (!m_mdu_busy) m_mem_waiting = 1;
      end else if (m_mem_waiting) begin
        m_mem_waiting = 0;
      end else if (m_mdu_busy) begin
        if (mdu_done) m_mdu_busy = 0;
      end else if (mdu_op_ex) begin
        m_mdu_busy = 1;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s/%s observed=%0d expected=%0d", phase, tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [4:0] r1, input logic [4:0] r2,
                               input logic br, input logic [4:0] rdx, input logic rwx,
                               input logic ldx, input logic mdu, input logic [4:0] rdm,
                               input logic ldm, input logic req, input logic ack,
                               input logic done);
    reset = rst; rs1_id = r1; rs2_id = r2; branch_id = br; rd_ex = rdx;
    reg_write_ex = rwx; load_ex = ldx; mdu_op_ex = mdu; rd_mem = rdm;
    load_mem = ldm; dmem_req = req; dmem_ack = ack; mdu_done = done;
  endtask

  // Check every output mid-cycle, then cross the clock edge.
  task automatic step();
    #2;
    model_outputs();
    checkOutput("mdu_start", mdu_start, e_start);
    checkOutput("pc_en", pc_en, e_pc);
    checkOutput("if_id_en", if_id_en, e_ifid);
    checkOutput("id_ex_en", id_ex_en, e_idex);
    checkOutput("ex_mem_en", ex_mem_en, e_exmem);
    checkOutput("mem_wb_en", mem_wb_en, e_memwb);
    checkOutput("id_ex_flush", id_ex_flush, e_fidex);
    checkOutput("ex_mem_flush", ex_mem_flush, e_fexmem);
    checkOutput("mem_wb_flush", mem_wb_flush, e_fmemwb);
    checkOutput("stall_cycles", stall_cycles, m_cnt);
    @(posedge clk);
    #1;
    model_advance();
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;

    phase = "reset";
    step();
    checkOutput("reset_count", stall_cycles, 0);

    phase = "load_use";
    applyStimulus(0, 5, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0); step();
    applyStimulus(0, 5, 1, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0); step();
    idle(); step();
    checkOutput("load_use_count", stall_cycles, 1);

    phase = "x0_rule";
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0); step();
    applyStimulus(0, 0, 0, 1, 0, 1, 1, 0, 0, 1, 0, 0, 0); step();

    phase = "branch_load";
    applyStimulus(0, 7, 2, 1, 7, 1, 1, 0, 0, 0, 0, 0, 0); step();
    applyStimulus(0, 7, 2, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0); step();
    applyStimulus(0, 7, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    phase = "branch_alu";
    applyStimulus(0, 2, 7, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0); step();
    applyStimulus(0, 2, 7, 1, 0, 0, 0, 0, 7, 0, 0, 0, 0); step();

    phase = "mdu";
    applyStimulus(0, 0, 0, 0, 9, 1, 0, 1, 0, 0, 0, 0, 0); step();
    applyStimulus(0, 0, 0, 0, 9, 1, 0, 1, 0, 0, 0, 0, 0); step();
    step();
    applyStimulus(0, 0, 0, 0, 9, 1, 0, 1, 0, 0, 0, 0, 1); step();
    idle(); step();

    phase = "mem_wait_mdu";
    applyStimulus(0, 0, 0, 0, 9, 1, 0, 1, 3, 0, 0, 0, 0); step();
    step();
    applyStimulus(0, 0, 0, 0, 9, 1, 0, 1, 3, 0, 1, 0, 0); step();
    applyStimulus(0, 0, 0, 0, 9, 1, 0, 1, 3, 0, 1, 0, 1); step();
    step();
    step();
    applyStimulus(0, 0, 0, 0, 9, 1, 0, 1, 3, 0, 1, 1, 1); step();
    idle(); step();

    phase = "mem_wait_run";
    applyStimulus(0, 4, 0, 0, 4, 1, 1, 0, 3, 0, 1, 0, 0); step();
    step();
    applyStimulus(0, 4, 0, 0, 4, 1, 1, 0, 3, 0, 1, 1, 0); step();
    idle(); step();

    phase = "reset_in_mdu";
    applyStimulus(0, 0, 0, 0, 9, 1, 0, 1, 0, 0, 0, 0, 0); step();
    step();
    applyStimulus(1, 0, 0, 0, 9, 1, 0, 1, 0, 0, 0, 0, 1); step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); step();
    checkOutput("post_reset_count", stall_cycles, 0);
    idle(); step();

    phase = "saturate";
    applyStimulus(0, 0, 0, 0, 9, 1, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 18; i++) step();
    checkOutput("saturated_count", stall_cycles, CNT_MAX);
    step();
    checkOutput("still_saturated", stall_cycles, CNT_MAX);
    applyStimulus(0, 0, 0, 0, 9, 1, 0, 1, 0, 0, 0, 0, 1); step();
    idle(); step();

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(39) == 0),
                    5'($urandom_range(3)), 5'($urandom_range(3)),
                    ($urandom_range(2) == 0),
                    5'($urandom_range(3)), ($urandom_range(1) == 0),
                    ($urandom_range(2) == 0), ($urandom_range(5) == 0),
                    5'($urandom_range(3)), ($urandom_range(2) == 0),
                    ($urandom_range(3) == 0), ($urandom_range(1) == 0),
                    ($urandom_range(2) == 0));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
